// File: rtl/echo_fifo_if.sv
// Receiver-to-transmitter echo path bundle for echo_fifo.
// slave = the FIFO itself; master = the surrounding UART glue (or a bench).
interface echo_fifo_if #(parameter int LGFLEN = 4);
  logic              i_rx_stb;
  logic [7:0]        i_rx_data;
  logic              i_rx_perr;
  logic              i_rx_ferr;
  logic              o_tx_stb;
  logic [7:0]        o_tx_data;
  logic              i_tx_busy;
  logic [LGFLEN:0]   o_fill;
  logic              o_overflow;
  logic              o_err;

  modport slave (
    input  i_rx_stb, i_rx_data, i_rx_perr, i_rx_ferr, i_tx_busy,
    output o_tx_stb, o_tx_data, o_fill, o_overflow, o_err
  );

  modport master (
    output i_rx_stb, i_rx_data, i_rx_perr, i_rx_ferr, i_tx_busy,
    input  o_tx_stb, o_tx_data, o_fill, o_overflow, o_err
  );
endinterface

// File: rtl/echo_fifo.sv
// Echo-path byte FIFO between UART RX and TX with busy handshake and sticky drop flags.
// Optional CR->CRLF expansion is enabled by defining ECHO_FIFO_CRLF_EN.
module echo_fifo #(
  parameter int LGFLEN = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  echo_fifo_if.slave bus
);
  localparam int DEPTH = 1 << LGFLEN;

  logic [7:0]        r_mem [DEPTH];
  logic [LGFLEN-1:0] r_rd, r_wr;
  logic [LGFLEN:0]   r_fill;
  logic              r_tx_stb;
  logic [7:0]        r_tx_data;
  logic              r_overflow, r_err;

  logic              w_pop, w_push, w_wr, w_ovf, w_rx_bad;
  logic [7:0]        w_wdata;
  logic [LGFLEN+1:0] w_free;
  logic [LGFLEN:0]   w_fill_next, w_fill_after_pop;
  logic [LGFLEN-1:0] w_rd_next;

`ifdef ECHO_FIFO_CRLF_EN
  logic              r_lf_pend;
  logic              w_lf_set;
`endif

  assign w_pop    = r_tx_stb && !bus.i_tx_busy;
  assign w_rx_bad = bus.i_rx_stb && (bus.i_rx_perr || bus.i_rx_ferr);
  assign w_push   = bus.i_rx_stb && !bus.i_rx_perr && !bus.i_rx_ferr;
  // Free slots counting an entry leaving this same cycle.
  assign w_free   = (LGFLEN+2)'(DEPTH) - (LGFLEN+2)'(r_fill) + (LGFLEN+2)'(w_pop);

  always_comb begin
    w_wr    = 1'b0;
    w_wdata = bus.i_rx_data;
    w_ovf   = 1'b0;
`ifdef ECHO_FIFO_CRLF_EN
    w_lf_set = 1'b0;
    if (r_lf_pend) begin
      // The inserted LF owns the write port; any strobe this cycle is lost.
      w_wr    = 1'b1;
      w_wdata = 8'h0A;
      w_ovf   = bus.i_rx_stb;
    end else if (w_push) begin
      if (bus.i_rx_data == 8'h0D) begin
        if (w_free >= (LGFLEN+2)'(2)) begin
          w_wr     = 1'b1;
          w_lf_set = 1'b1;
        end else begin
          w_ovf = 1'b1;
        end
      end else if (w_free != '0) begin
        w_wr = 1'b1;
      end else begin
        w_ovf = 1'b1;
      end
    end
`else
    if (w_push) begin
      if (w_free != '0) w_wr  = 1'b1;
      else              w_ovf = 1'b1;
    end
`endif
  end

  assign w_fill_after_pop = r_fill - (LGFLEN+1)'(w_pop);
  assign w_fill_next      = w_fill_after_pop + (LGFLEN+1)'(w_wr);
  assign w_rd_next        = r_rd + LGFLEN'(w_pop);

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr] <= w_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd       <= '0;
      r_wr       <= '0;
      r_fill     <= '0;
      r_tx_stb   <= 1'b0;
      r_tx_data  <= 8'h00;
      r_overflow <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd     <= w_rd_next;
      r_wr     <= r_wr + LGFLEN'(w_wr);
      r_fill   <= w_fill_next;
      // A pop forces one idle cycle so TX busy is seen before the next issue.
      r_tx_stb <= (w_fill_next != '0) && !w_pop;
      // Head byte bypasses the memory when the write lands at the new head.
      if (w_wr && (w_fill_after_pop == '0))
        r_tx_data <= w_wdata;
      else if (w_fill_next != '0)
        r_tx_data <= r_mem[w_rd_next];
      if (w_ovf)    r_overflow <= 1'b1;
      if (w_rx_bad) r_err      <= 1'b1;
    end
  end

`ifdef ECHO_FIFO_CRLF_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) r_lf_pend <= 1'b0;
    else         r_lf_pend <= w_lf_set;
  end
`endif

  assign bus.o_tx_stb   = r_tx_stb;
  assign bus.o_tx_data  = r_tx_data;
  assign bus.o_fill     = r_fill;
  assign bus.o_overflow = r_overflow;
  assign bus.o_err      = r_err;
endmodule

// File: tb/tb_echo_fifo.sv
// Bench for echo_fifo: queue-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_echo_fifo;
  localparam int LGFLEN = 4;
  localparam int DEPTH  = 1 << LGFLEN;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  echo_fifo_if #(.LGFLEN(LGFLEN)) bus ();
  echo_fifo #(.LGFLEN(LGFLEN)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a plain byte queue plus the spec's rules.
  logic [7:0] q[$];
  bit m_hold = 0, m_ovf = 0, m_err = 0, m_lfp = 0;
  bit started = 0;
  logic [7:0] emitted[$];

  always @(posedge clk) begin
    bit m_stb, pop, good;
    int free;
    if (rst) begin
      q.delete(); m_hold = 0; m_ovf = 0; m_err = 0; m_lfp = 0;
      started = 1;
    end else if (started) begin
      m_stb = (q.size() != 0) && !m_hold;
      pop   = m_stb && !bus.i_tx_busy;
      free  = DEPTH - q.size() + (pop ? 1 : 0);
      if (pop) void'(q.pop_front());
      m_hold = pop;
      good = bus.i_rx_stb && !bus.i_rx_perr && !bus.i_rx_ferr;
      if (bus.i_rx_stb && (bus.i_rx_perr || bus.i_rx_ferr)) m_err = 1;
      if (m_lfp) begin
        q.push_back(8'h0A);
        if (bus.i_rx_stb) m_ovf = 1;
        m_lfp = 0;
      end else if (good) begin
`ifdef ECHO_FIFO_CRLF_EN
        if (bus.i_rx_data == 8'h0D) begin
          if (free >= 2) begin q.push_back(8'h0D); m_lfp = 1; end
          else m_ovf = 1;
        end else
`endif
        if (free >= 1) q.push_back(bus.i_rx_data);
        else m_ovf = 1;
      end
    end
  end

  // Per-cycle compare, sampled mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      bit es;
      es = (q.size() != 0) && !m_hold;
      chk("tx_stb", int'(bus.o_tx_stb), int'(es));
      chk("fill", int'(bus.o_fill), q.size());
      chk("overflow", int'(bus.o_overflow), int'(m_ovf));
      chk("err", int'(bus.o_err), int'(m_err));
      if (es) chk("tx_data", int'(bus.o_tx_data), int'(q[0]));
      if (bus.o_tx_stb && !bus.i_tx_busy) emitted.push_back(bus.o_tx_data);
    end
  end

  task automatic cyc(input bit stb, input logic [7:0] d, input bit pe, input bit fe,
                     input bit busy, input bit r);
    bus.i_rx_stb = stb; bus.i_rx_data = d; bus.i_rx_perr = pe;
    bus.i_rx_ferr = fe; bus.i_tx_busy = busy; rst = r;
    @(posedge clk); #2;
  endtask

  task automatic idle(input bit busy, input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0, busy, 0);
  endtask

  task automatic do_reset();
    cyc(0, 8'h00, 0, 0, 1, 1);
    cyc(0, 8'h00, 0, 0, 1, 1);
  endtask

  initial begin
    bus.i_rx_stb = 0; bus.i_rx_data = 0; bus.i_rx_perr = 0;
    bus.i_rx_ferr = 0; bus.i_tx_busy = 1;

    // Reset state
    do_reset();
    chk("rst_fill", int'(bus.o_fill), 0);
    chk("rst_stb", int'(bus.o_tx_stb), 0);
    chk("rst_ovf", int'(bus.o_overflow), 0);
    chk("rst_err", int'(bus.o_err), 0);

    // Single byte, latency 1, then holdoff
    cyc(1, 8'h41, 0, 0, 0, 0);
    chk("t1_stb", int'(bus.o_tx_stb), 1);
    chk("t1_data", int'(bus.o_tx_data), 8'h41);
    cyc(0, 8'h00, 0, 0, 0, 0);
    chk("t1_fill0", int'(bus.o_fill), 0);
    chk("t1_stb0", int'(bus.o_tx_stb), 0);

    // Fill to full, overflow, then drain in order
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0, 0, 1, 0);
    cyc(1, 8'h10, 0, 0, 1, 0);
    chk("t2_fill", int'(bus.o_fill), DEPTH);
    chk("t2_ovf", int'(bus.o_overflow), 1);
    emitted.delete();
    idle(0, 40);
    chk("t2_count", emitted.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < emitted.size(); i++)
      chk("t2_order", int'(emitted[i]), i);

    // Full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'hA0 + 8'(i), 0, 0, 1, 0);
    emitted.delete();
    cyc(1, 8'h55, 0, 0, 0, 0);
    chk("t3_fill", int'(bus.o_fill), DEPTH);
    chk("t3_ovf", int'(bus.o_overflow), 0);
    idle(0, 40);
    chk("t3_count", emitted.size(), DEPTH + 1);
    if (emitted.size() == DEPTH + 1) begin
      chk("t3_first", int'(emitted[0]), 8'hA0);
      chk("t3_last", int'(emitted[DEPTH]), 8'h55);
    end

    // Errored bytes are discarded
    do_reset();
    cyc(1, 8'h33, 0, 1, 0, 0);
    cyc(1, 8'h34, 1, 0, 0, 0);
    idle(0, 1);
    chk("t4_fill", int'(bus.o_fill), 0);
    chk("t4_err", int'(bus.o_err), 1);
    chk("t4_stb", int'(bus.o_tx_stb), 0);

    // Reset mid-drain
    cyc(1, 8'h01, 0, 0, 1, 0);
    cyc(1, 8'h02, 0, 0, 1, 0);
    cyc(1, 8'h03, 0, 0, 1, 0);
    idle(0, 1);
    cyc(0, 8'h00, 0, 0, 0, 1);
    chk("t5_fill", int'(bus.o_fill), 0);
    chk("t5_stb", int'(bus.o_tx_stb), 0);
    chk("t5_err", int'(bus.o_err), 0);
    chk("t5_ovf", int'(bus.o_overflow), 0);
    emitted.delete();
    cyc(1, 8'h7E, 0, 0, 0, 0);
    idle(0, 6);
    chk("t5_count", emitted.size(), 1);
    if (emitted.size() == 1) chk("t5_byte", int'(emitted[0]), 8'h7E);

    // CR handling
    do_reset();
    emitted.delete();
    cyc(1, 8'h0D, 0, 0, 0, 0);
    idle(0, 8);
`ifdef ECHO_FIFO_CRLF_EN
    chk("t6_count", emitted.size(), 2);
    if (emitted.size() == 2) begin
      chk("t6_cr", int'(emitted[0]), 8'h0D);
      chk("t6_lf", int'(emitted[1]), 8'h0A);
    end
    do_reset();
    for (int i = 0; i < DEPTH - 1; i++) cyc(1, 8'h20 + 8'(i), 0, 0, 1, 0);
    cyc(1, 8'h0D, 0, 0, 1, 0);
    chk("t6_fill", int'(bus.o_fill), DEPTH - 1);
    chk("t6_ovf", int'(bus.o_overflow), 1);
    do_reset();
    cyc(1, 8'h0D, 0, 0, 1, 0);
    cyc(1, 8'h22, 0, 0, 1, 0);
    chk("t6_col_fill", int'(bus.o_fill), 2);
    chk("t6_col_ovf", int'(bus.o_overflow), 1);
`else
    chk("t6_count", emitted.size(), 1);
    if (emitted.size() == 1) chk("t6_cr", int'(emitted[0]), 8'h0D);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit s, pe, fe, b, r;
      logic [7:0] d;
      s  = ($urandom_range(0, 1) == 1);
      d  = ($urandom_range(0, 5) == 0) ? 8'h0D : 8'($urandom);
      pe = ($urandom_range(0, 11) == 0) && !m_lfp;
      fe = ($urandom_range(0, 11) == 0) && !m_lfp;
      b  = ($urandom_range(0, 2) != 0);
      r  = ($urandom_range(0, 499) == 0);
      cyc(s, d, pe, fe, b, r);
    end
    idle(0, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/echo_fifo.md
Name: echo_fifo

Overview:
- Buffering stage between the UART receiver and the UART transmitter in the echo path.
- Takes received bytes on the receiver's strobe and queues them in a small FIFO.
- Issues queued bytes to the transmitter using its busy handshake.
- Absorbs short-term rate mismatch, so a receiver running slightly fast does not drop characters. Bytes received with parity or framing errors are discarded.

Parameters:
- LGFLEN, 4, log2 of FIFO depth; depth = 2^LGFLEN entries of 8 bits. Legal range 1..10.

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  synchronous, active-high reset
- i_rx_stb  input  1  one-cycle strobe: i_rx_data valid
- i_rx_data  input  8  received byte
- i_rx_perr  input  1  parity error, qualified by i_rx_stb
- i_rx_ferr  input  1  frame error, qualified by i_rx_stb
- o_tx_stb  output  1  byte available to transmitter (txuart i_wr)
- o_tx_data  output  8  byte to transmit, valid while o_tx_stb
- i_tx_busy  input  1  transmitter busy; transfer only when low
- o_fill  output  LGFLEN+1  current entry count, 0..2^LGFLEN
- o_overflow  output  1  sticky: a byte was dropped because the FIFO was full
- o_err  output  1  sticky: a byte was dropped because of perr/ferr

Behaviour:
- Reset values (sync, i_reset high at posedge):
  - read/write pointers = 0, o_fill = 0
  - o_tx_stb = 0, o_tx_data = 0
  - o_overflow = 0, o_err = 0, holdoff = 0, pending-LF (if enabled) = 0
- Reset mid-operation discards all queued bytes. A byte already accepted by the transmitter is unaffected.
- Push qualification: push = i_rx_stb && !i_rx_perr && !i_rx_ferr.
  - i_rx_stb with perr or ferr: byte discarded, o_err <= 1.
- Pop: on any cycle with o_tx_stb && !i_tx_busy.
- Full (o_fill == 2^LGFLEN), push without pop: byte dropped, o_overflow <= 1, FIFO contents unchanged.
- Full, push with simultaneous pop: push accepted, o_fill stays at 2^LGFLEN.
- Empty with push: no pop that cycle. o_tx_stb first rises the cycle after the push (latency 1).
- o_tx_stb = (o_fill != 0) && !holdoff.
  - o_tx_data = mem[rd_ptr], driven from registered head data so it is stable whenever o_tx_stb is high.
- Holdoff: set for exactly one cycle after every pop. This guarantees the transmitter's busy has risen before the next issue, so the same byte is never double-issued.
- Pointers: LGFLEN bits, wrap modulo 2^LGFLEN. o_fill = pushes − pops, never exceeds 2^LGFLEN and never underflows.
- Byte order strictly preserved; no byte is duplicated.
- Sticky flags are cleared only by i_reset.

Optional Feature:
- Macro: ECHO_FIFO_CRLF_EN
- Defined: a pushed 0x0D is followed by an automatic 0x0A push on the next cycle.
  - CR is accepted only when at least 2 entries are free (counting a same-cycle pop). Otherwise both CR and LF are dropped and o_overflow <= 1.
  - While the pending LF is inserted, an i_rx_stb in that same cycle is dropped with o_overflow <= 1. This cannot occur with UART frame spacing, but the bench checks it.
- Undefined: 0x0D is treated as an ordinary byte; no pending-LF state exists.

Test Plan:
- Reset, then push 0x41 with i_tx_busy=0 -> o_tx_stb high the next cycle with o_tx_data=0x41. Pop occurs, o_fill returns to 0, o_tx_stb low for ≥1 cycle.
- i_tx_busy=1, push 16 bytes 0x00..0x0F (LGFLEN=4), then push 0x10 -> o_fill=16, o_overflow=1. Release busy -> exactly 0x00..0x0F emitted in order, 0x10 never emitted.
- FIFO full, busy low, push 0x55 on the same cycle as a pop -> 0x55 retained, o_fill stays 16, o_overflow stays 0.
- Push 0x33 with i_rx_ferr=1, then 0x34 with i_rx_perr=1 -> nothing queued, o_fill=0, o_err=1.
- Push 3 bytes, assert i_reset mid-drain -> o_fill=0, o_tx_stb=0, sticky flags clear. The next push 0x7E is emitted alone.
- With ECHO_FIFO_CRLF_EN: push 0x0D -> emitted sequence 0x0D, 0x0A. With 1 free entry, push 0x0D -> nothing added, o_overflow=1.
